fifo_stream_reader: RTL and testbench

Read-side controller that drains the fixed-point `fifo` (IL.FL words) and presents its contents as a valid/ready stream to a downstream consumer (processing element, output serializer). It owns `rd_en` and absorbs the FIFO's one-cycle read latency with a two-entry skid buffer. This sustains one word per cycle while preserving order and never reading an empty FIFO.

---
 rtl/fifo_stream_reader.sv | 105 ++++++++++
 tb/tb_fifo_stream_reader.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - FIFO read-side controller with two-entry skid buffer and valid/ready output stream
module fifo_stream_reader #(
  parameter int IL           = 4,
  parameter int FL           = 16,
  parameter int IN_BUS_WIDTH = IL + FL,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    fifo_empty,
  input  logic [IN_BUS_WIDTH-1:0] fifo_data,
  output logic                    fifo_rd_en,
  input  logic                    flush,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [IN_BUS_WIDTH-1:0] out_data,
  output logic [1:0]              occupancy,
  output logic [CNT_WIDTH-1:0]    words_out
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t                  state;
  logic                    inflight;
  logic [IN_BUS_WIDTH-1:0] head;
  logic [IN_BUS_WIDTH-1:0] skid;
  logic                    pop;
  logic                    arrival;
  logic [2:0]              level;

  assign pop     = out_valid & out_ready;
  assign arrival = inflight;

  // Words committed after this edge: buffered plus in flight, minus the one leaving.
  // pop implies state != EMPTY, so this never underflows.
  assign level = {1'b0, state} + {2'b00, inflight} - {2'b00, pop};

  // Issue a read only when the word it returns is guaranteed a slot; out_ready
  // feeds this path combinationally so a pop frees space in the same cycle.
  assign fifo_rd_en = !reset && !flush && !fifo_empty && (level < 3'd2);

  assign out_valid = (state != EMPTY);
  assign out_data  = head;
  assign occupancy = state;

  // Occupancy FSM, word registers, read-latency tracking and accepted-word counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= EMPTY;
      inflight  <= 1'b0;
      head      <= '0;
      skid      <= '0;
      words_out <= '0;
    end else begin
      // fifo_rd_en is already low during flush, so this also clears inflight then.
      inflight <= fifo_rd_en;

      if (pop) begin
        words_out <= words_out + 1'b1;
      end

      if (flush) begin
        // Buffered words and any word landing this edge are dropped.
        state <= EMPTY;
      end else begin
        case (state)
          EMPTY: begin
            if (arrival) begin
              head  <= fifo_data;
              state <= ONE;
            end
          end
          ONE: begin
            case ({pop, arrival})
              2'b10: state <= EMPTY;
              2'b01: begin
                skid  <= fifo_data;
                state <= TWO;
              end
              2'b11: head <= fifo_data;
              default: ;
            endcase
          end
          TWO: begin
            // Arrival without pop is unreachable: the read gate keeps level <= 2.
            if (pop) begin
              head <= skid;
              if (arrival) begin
                skid <= fifo_data;
              end else begin
                state <= ONE;
              end
            end
          end
          default: state <= EMPTY;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - self-checking bench for fifo_stream_reader
module tb_fifo_stream_reader;

  localparam int W = 20;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          fifo_empty;
  logic [W-1:0]  fifo_data = '0;
  logic          fifo_rd_en;
  logic          flush = 1'b0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic [1:0]    occupancy;
  logic [15:0]   words_out;

  int            fcount = 0;
  logic [W-1:0]  fq[$];
  logic [W-1:0]  exp_q[$];
  int            checks = 0;
  int            errors = 0;
  logic          last_rd;
  logic          last_valid;
  logic          last_pop;

  assign fifo_empty = (fcount == 0);

  fifo_stream_reader #(.IL(4), .FL(16), .IN_BUS_WIDTH(W), .CNT_WIDTH(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .flush      (flush),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .occupancy  (occupancy),
    .words_out  (words_out)
  );

  always #5 clk = ~clk;

  // One clock: sample and score at negedge, then model the FIFO at posedge.
  task automatic step();
    logic [W-1:0] w;
    @(negedge clk);
    last_rd    = fifo_rd_en;
    last_valid = out_valid;
    last_pop   = out_valid && out_ready;
    checks++;
    if (fifo_rd_en && fifo_empty) begin
      errors++;
      $display("FAIL rd_on_empty: rd_en=%0b empty=%0b, required no read", fifo_rd_en, fifo_empty);
    end
    checks++;
    if (occupancy > 2'd2) begin
      errors++;
      $display("FAIL occupancy_max: got %0d, required <= 2", occupancy);
    end
    checks++;
    if (occupancy == 2'd2 && dut.inflight && !last_pop && !flush) begin
      errors++;
      $display("FAIL two_arrival_no_pop: occupancy=%0d inflight=1 pop=0, required unreachable", occupancy);
    end
    if (last_pop) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL extra_word: got %h, required no word", out_data);
      end else begin
        w = exp_q.pop_front();
        if (out_data !== w) begin
          errors++;
          $display("FAIL data_order: got %h, required %h", out_data, w);
        end
      end
    end
    @(posedge clk);
    if (fifo_rd_en && fcount > 0) begin
      w = fq.pop_front();
      fifo_data <= w;
    end
    fcount <= fq.size();
    #1;
  endtask

  task automatic push(input logic [W-1:0] w);
    fq.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d words outstanding, required 0", exp_q.size());
    end
    repeat (3) step();
  endtask

  task automatic test_reset();
    repeat (2) step();
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || occupancy !== 2'd0 ||
        words_out !== 16'd0 || fifo_rd_en !== 1'b0 || dut.inflight !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: valid=%0b data=%h occ=%0d words=%0d rd=%0b, required all 0",
               out_valid, out_data, occupancy, words_out, fifo_rd_en);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_single();
    int rd, v;
    rd = 0; v = 0;
    out_ready = 1'b1;
    push(20'd101);
    repeat (8) begin
      step();
      rd += int'(last_rd);
      v  += int'(last_valid);
    end
    checks++;
    if (rd != 1) begin errors++; $display("FAIL single_reads: got %0d, required 1", rd); end
    checks++;
    if (v != 1) begin errors++; $display("FAIL single_valid_cycles: got %0d, required 1", v); end
    checks++;
    if (words_out !== 16'd1) begin errors++; $display("FAIL single_words: got %0d, required 1", words_out); end
    checks++;
    if (occupancy !== 2'd0) begin errors++; $display("FAIL single_occ: got %0d, required 0", occupancy); end
  endtask

  task automatic test_back_to_back();
    int rd_first, rd_last, rd_cnt, v_first, v_last, v_cnt;
    rd_first = -1; rd_last = -1; rd_cnt = 0;
    v_first = -1; v_last = -1; v_cnt = 0;
    for (int w = 102; w <= 104; w++) push(W'(w));
    for (int i = 0; i < 12; i++) begin
      step();
      if (last_rd) begin
        if (rd_first < 0) rd_first = i;
        rd_last = i;
        rd_cnt++;
      end
      if (last_valid) begin
        if (v_first < 0) v_first = i;
        v_last = i;
        v_cnt++;
      end
    end
    checks++;
    if (rd_cnt != 3 || rd_last - rd_first != 2) begin
      errors++;
      $display("FAIL b2b_reads: got %0d reads over span %0d, required 3 over 2", rd_cnt, rd_last - rd_first);
    end
    checks++;
    if (v_cnt != 3 || v_last - v_first != 2) begin
      errors++;
      $display("FAIL b2b_valid: got %0d valid over span %0d, required 3 over 2", v_cnt, v_last - v_first);
    end
    checks++;
    if (words_out !== 16'd4) begin errors++; $display("FAIL b2b_words: got %0d, required 4", words_out); end
  endtask

  task automatic test_backpressure();
    int rd, pops;
    rd = 0; pops = 0;
    out_ready = 1'b0;
    for (int w = 201; w <= 208; w++) push(W'(w));
    repeat (6) begin
      step();
      rd += int'(last_rd);
    end
    checks++;
    if (rd != 2) begin errors++; $display("FAIL bp_reads: got %0d, required 2", rd); end
    checks++;
    if (occupancy !== 2'd2 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_occ: got occ=%0d valid=%0b, required occ=2 valid=1", occupancy, out_valid);
    end
    checks++;
    if (out_data !== 20'd201) begin errors++; $display("FAIL bp_head: got %0d, required 201", out_data); end
    out_ready = 1'b1;
    repeat (8) begin
      step();
      pops += int'(last_pop);
    end
    checks++;
    if (pops != 8) begin errors++; $display("FAIL bp_release: got %0d pops in 8 cycles, required 8", pops); end
    drain(10);
    checks++;
    if (words_out !== 16'd12) begin errors++; $display("FAIL bp_words: got %0d, required 12", words_out); end
  endtask

  task automatic test_toggle();
    int n;
    n = 0;
    for (int w = 301; w <= 310; w++) push(W'(w));
    while (exp_q.size() != 0 && n < 80) begin
      out_ready = (n % 2 == 0);
      step();
      n++;
    end
    out_ready = 1'b1;
    drain(10);
    checks++;
    if (words_out !== 16'd22 || occupancy !== 2'd0) begin
      errors++;
      $display("FAIL toggle_end: got words=%0d occ=%0d, required words=22 occ=0", words_out, occupancy);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int w = 401; w <= 408; w++) push(W'(w));
    repeat (6) step();
    checks++;
    if (occupancy !== 2'd2) begin errors++; $display("FAIL flush_pre_occ: got %0d, required 2", occupancy); end
    // Pop 401 in the flush cycle; 402 in the skid register is dropped.
    flush = 1'b1;
    out_ready = 1'b1;
    #1;
    checks++;
    if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL flush_rd_en: got %0b, required 0", fifo_rd_en); end
    step();
    flush = 1'b0;
    out_ready = 1'b0;
    void'(exp_q.pop_front());
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      errors++;
      $display("FAIL flush_clear: got valid=%0b occ=%0d, required 0 0", out_valid, occupancy);
    end
    checks++;
    if (words_out !== 16'd23) begin errors++; $display("FAIL flush_words: got %0d, required 23", words_out); end
    out_ready = 1'b1;
    drain(20);
    checks++;
    if (words_out !== 16'd29) begin errors++; $display("FAIL flush_after_words: got %0d, required 29", words_out); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int w = 501; w <= 508; w++) push(W'(w));
    repeat (6) step();
    checks++;
    if (occupancy !== 2'd2) begin errors++; $display("FAIL rst_pre_occ: got %0d, required 2", occupancy); end
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || occupancy !== 2'd0 ||
        words_out !== 16'd0 || fifo_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL rst_async: valid=%0b data=%h occ=%0d words=%0d rd=%0b, required all 0",
               out_valid, out_data, occupancy, words_out, fifo_rd_en);
    end
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    repeat (2) step();
    reset = 1'b0;
    out_ready = 1'b1;
    drain(20);
    checks++;
    if (words_out !== 16'd6) begin errors++; $display("FAIL rst_resume_words: got %0d, required 6", words_out); end
  endtask

  task automatic test_wrap();
    out_ready = 1'b1;
    for (int i = 0; i < 65529; i++) push(W'(i) ^ 20'hA5A5A);
    drain(70000);
    checks++;
    if (words_out !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload: got %0d, required 65535", words_out); end
    push(20'hFFFFF);
    drain(20);
    checks++;
    if (words_out !== 16'd0) begin errors++; $display("FAIL wrap_zero: got %0d, required 0", words_out); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_toggle();
    test_flush();
    test_reset_mid();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
